// File: rtl/input_fifo_pkg.sv
// Shared definitions for the input FIFO and its load-extraction datapath.
// Holds the CPU load-type encodings and the word/half/byte widths used by
// every path that turns a stored word into a load result.
package input_fifo_pkg;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;
  localparam int BYTE_W = 8;

endpackage

// File: rtl/load_extract.sv
// Purely combinational load extraction: picks a byte, halfword or word out
// of a 32-bit head word and sign- or zero-extends it. An invalid head
// (nothing queued) yields zero so the CPU never sees stale storage.
module load_extract
  import input_fifo_pkg::*;
(
  input  logic [WORD_W-1:0] head,
  input  logic [2:0]        data_type,
  input  logic [1:0]        data_offset,
  input  logic              valid,
  output logic [WORD_W-1:0] cpu_out
);

  logic [WORD_W-1:0] shifted;
  logic [BYTE_W-1:0] byte_v;
  logic [HALF_W-1:0] half_v;

  // Select the addressed byte/half and extend according to the load type
  always_comb begin
    cpu_out = '0;
    shifted = head >> {data_offset, 3'b000};
    byte_v  = shifted[BYTE_W-1:0];
    half_v  = data_offset[1] ? head[WORD_W-1:HALF_W] : head[HALF_W-1:0];
    if (valid) begin
      case (data_type)
        LT_LB:   cpu_out = {{(WORD_W-BYTE_W){byte_v[BYTE_W-1]}}, byte_v};
        LT_LBU:  cpu_out = {{(WORD_W-BYTE_W){1'b0}}, byte_v};
        LT_LH:   cpu_out = {{(WORD_W-HALF_W){half_v[HALF_W-1]}}, half_v};
        LT_LHU:  cpu_out = {{(WORD_W-HALF_W){1'b0}}, half_v};
        default: cpu_out = head;
      endcase
    end
  end

endmodule

// File: rtl/input_fifo.sv
// Input FIFO between the peripheral input bus and the CPU load-data mux.
// Circular storage of DEPTH 32-bit words with separate write/read pointers
// and an occupancy counter; the oldest word is presented through
// load_extract. The sticky overflow flag exists only when the macro
// INPUT_FIFO_OVERFLOW_EN is defined; otherwise overflow is tied low.
module input_fifo
  import input_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              write,
  input  logic [WORD_W-1:0] io_in,
  input  logic              read,
  input  logic [2:0]        data_type,
  input  logic [1:0]        data_offset,
  output logic [WORD_W-1:0] cpu_out,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  input  logic              clear_overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [PTR_W-1:0]  rp_q, rp_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_en, pop_en, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

  // Accept/drop decisions and next pointer/count values; a read frees the slot a same-edge write needs
  always_comb begin
    pop_en  = read && !empty;
    push_en = write && (!full || read);
    drop    = write && full && !read;
    wp_d    = push_en ? wp_q + PTR_W'(1) : wp_q;
    rp_d    = pop_en  ? rp_q + PTR_W'(1) : rp_q;
    count_d = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the queue immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage array, deliberately left unreset since empty masks its contents
  always_ff @(posedge clock) begin
    if (push_en) begin
      mem_q[wp_q] <= io_in;
    end
  end

`ifdef INPUT_FIFO_OVERFLOW_EN
  logic overflow_q, overflow_d;

  // Sticky drop flag; a new drop on the same edge as a clear keeps it set
  always_comb begin
    overflow_d = overflow_q;
    if (clear_overflow) overflow_d = 1'b0;
    if (drop)           overflow_d = 1'b1;
  end

  // Overflow flag register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) overflow_q <= 1'b0;
    else          overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`else
  logic unused_ovf;
  assign unused_ovf = clear_overflow ^ drop;
  assign overflow   = 1'b0;
`endif

  load_extract u_extract (
    .head        (mem_q[rp_q]),
    .data_type   (data_type),
    .data_offset (data_offset),
    .valid       (!empty),
    .cpu_out     (cpu_out)
  );

endmodule

// File: tb/tb_input_fifo.sv
// Self-checking bench for input_fifo: a queue-based reference model is
// compared against the DUT on every falling clock edge, with directed
// literal checks for the load-extraction, full/drop, wrap and reset cases
// followed by randomized traffic.
module tb_input_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef INPUT_FIFO_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic             clock;
  logic             reset_n;
  logic             write;
  logic [31:0]      io_in;
  logic             read;
  logic [2:0]       data_type;
  logic [1:0]       data_offset;
  logic [31:0]      cpu_out;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             clear_overflow;

  int total = 0;
  int bad   = 0;

  logic [31:0] modelQ[$];
  logic        modelOvf = 1'b0;

  input_fifo #(.DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .write          (write),
    .io_in          (io_in),
    .read           (read),
    .data_type      (data_type),
    .data_offset    (data_offset),
    .cpu_out        (cpu_out),
    .empty          (empty),
    .full           (full),
    .count          (count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  // Free-running clock, period 10
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record one comparison and report it if it differs
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Load result from the rules: pick byte/half by arithmetic, then extend
  function automatic logic [31:0] modelLoad(input logic [31:0] h, input logic [2:0] t,
                                            input logic [1:0] o, input bit valid);
    int unsigned w, b, hw;
    if (!valid) return 32'h0;
    w  = h;
    b  = (w / (32'd1 << (8 * o))) % 256;
    hw = (o >= 2) ? (w / 65536) : (w % 65536);
    case (t)
      3'b000:  return (b  >= 128)   ? (b  + 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return (hw >= 32768) ? (hw + 32'hFFFF_0000) : hw;
      3'b101:  return hw;
      default: return h;
    endcase
  endfunction

  function automatic logic [31:0] expCpu();
    if (modelQ.size() == 0) return 32'h0;
    return modelLoad(modelQ[0], data_type, data_offset, 1'b1);
  endfunction

  // Reference model state update on each active edge
  always @(posedge clock) begin
    if (reset_n) begin
      bit doPop, doPush, drop;
      doPop  = read && (modelQ.size() > 0);
      doPush = write && ((modelQ.size() < DEPTH) || read);
      drop   = write && (modelQ.size() == DEPTH) && !read;
      if (doPop)  void'(modelQ.pop_front());
      if (doPush) modelQ.push_back(io_in);
      if (OVF_EN) begin
        if (clear_overflow) modelOvf = 1'b0;
        if (drop)           modelOvf = 1'b1;
      end
    end
  end

  // Asynchronous reset empties the model at once
  always @(negedge reset_n) begin
    modelQ.delete();
    modelOvf = 1'b0;
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clock) begin
    checkOutput("cyc_cpu_out", cpu_out, expCpu());
    checkOutput("cyc_count", 32'(count), modelQ.size());
    checkOutput("cyc_empty", 32'(empty), 32'(modelQ.size() == 0));
    checkOutput("cyc_full", 32'(full), 32'(modelQ.size() == DEPTH));
    checkOutput("cyc_overflow", 32'(overflow), 32'(modelOvf));
  end

  // Drive one edge worth of control inputs, then return them to idle
  task automatic applyStimulus(input logic w, input logic [31:0] d, input logic r, input logic clr);
    write = w; io_in = d; read = r; clear_overflow = clr;
    @(posedge clock);
    #1;
    write = 1'b0; read = 1'b0; clear_overflow = 1'b0;
  endtask

  // Change the load selection and let it settle away from the clock edges
  task automatic setLoad(input logic [2:0] t, input logic [1:0] o);
    data_type = t; data_offset = o;
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; write = 1'b0; io_in = '0; read = 1'b0;
    data_type = 3'b010; data_offset = 2'd0; clear_overflow = 1'b0;

    #2;
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_cpu_out", cpu_out, 32'h0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    #10 reset_n = 1'b1;
    @(posedge clock); #1;

    // Extraction variants on a single word
    applyStimulus(1'b1, 32'h8899_AABB, 1'b0, 1'b0);
    setLoad(3'b000, 2'd0); checkOutput("lb_off0", cpu_out, 32'hFFFF_FFBB);
    setLoad(3'b100, 2'd3); checkOutput("lbu_off3", cpu_out, 32'h0000_0088);
    setLoad(3'b001, 2'd2); checkOutput("lh_off2", cpu_out, 32'hFFFF_8899);
    setLoad(3'b101, 2'd1); checkOutput("lhu_off1", cpu_out, 32'h0000_AABB);
    setLoad(3'b010, 2'd3); checkOutput("lw_off3", cpu_out, 32'h8899_AABB);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("pop_to_empty", 32'(empty), 32'd1);

    // Fill, drop, drain in order
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_count", 32'(count), 32'd4);
    applyStimulus(1'b1, 32'd5, 1'b0, 1'b0);
    checkOutput("drop_overflow", 32'(overflow), 32'(OVF_EN));
    checkOutput("drop_count", 32'(count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("drain_%0d", i), cpu_out, 32'(i));
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    end
    checkOutput("drain_empty", 32'(empty), 32'd1);
    checkOutput("drain_cpu_out", cpu_out, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("clear_alone", 32'(overflow), 32'd0);

    // Read while empty is ignored
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("empty_read_count", 32'(count), 32'd0);
    checkOutput("empty_read_ovf", 32'(overflow), 32'd0);

    // Full FIFO with simultaneous read+write, then drain across the wrap
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd5, 1'b1, 1'b0);
    checkOutput("rw_full_count", 32'(count), 32'd4);
    checkOutput("rw_full_ovf", 32'(overflow), 32'd0);
    for (int i = 2; i <= 5; i++) begin
      checkOutput($sformatf("wrap_%0d", i), cpu_out, 32'(i));
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    end

    // Clear colliding with a drop: the drop wins
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 32'(10 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd99, 1'b0, 1'b1);
    checkOutput("clear_vs_drop", 32'(overflow), 32'(OVF_EN));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("clear_after", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream with three entries held
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    checkOutput("pre_rst_count", 32'(count), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_rst_count", 32'(count), 32'd0);
    checkOutput("async_rst_empty", 32'(empty), 32'd1);
    checkOutput("async_rst_cpu_out", cpu_out, 32'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Randomized traffic checked every cycle by the model
    for (int n = 0; n < 400; n++) begin
      data_type   = 3'($urandom_range(0, 7));
      data_offset = 2'($urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 99) < 60), $urandom,
                    1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 8));
    end

    @(posedge clock); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_fifo.md
# input_fifo

Parametrised successor to the single-register input buffer. Queues up to DEPTH 32-bit words from the I/O side and presents the oldest word to the CPU load path with byte/halfword/word extraction, sign or zero extension. The CPU pops entries explicitly. Status flags let software poll occupancy and detect dropped words. It sits between the peripheral input bus and the CPU's load-data mux.

## Interface
- DEPTH, 4, number of 32-bit entries; power of two, ≥2
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived; do not override)
- clock  input  1  rising-edge clock for all state
- reset_n  input  1  asynchronous, active-low reset
- write  input  1  push io_in on this edge
- io_in  input  32  I/O-side data word
- read  input  1  pop the head entry on this edge
- data_type  input  3  load type: 000 LB, 001 LH, 100 LBU, 101 LHU, others LW
- data_offset  input  2  byte address within the head word
- cpu_out  output  32  extracted and extended head data (combinational)
- empty  output  1  no entries held
- full  output  1  DEPTH entries held
- count  output  CNT_W  entries held, 0..DEPTH
- overflow  output  1  sticky: a push was dropped
- clear_overflow  input  1  clears overflow on this edge

## Operation
- Circular storage, write pointer wp and read pointer rp, each $clog2(DEPTH) bits, wrapping modulo DEPTH; count tracked separately.
- Push accepted when write && (!full || read); entry[wp] <= io_in, wp increments.
- Pop accepted when read && !empty; rp increments. A read while empty is ignored, with no state change and no flag.
- Simultaneous accepted push and pop: count unchanged; both pointers advance.
- Write while full without read: word dropped, storage and pointers unchanged, overflow set (see Configuration).
- Write while full with read: pop and push both accepted, count stays DEPTH, no overflow.
- clear_overflow together with a new drop on the same edge: set wins, so overflow = 1.
- Extraction operates on the head word H = entry[rp]:
  - Byte: B = H[8*data_offset+7 -: 8]. LBU gives {24'h0,B}. LB gives {{24{B[7]}},B}.
  - Half: selected by data_offset[1] only; data_offset[0] is ignored. Offset 0/1 gives H[15:0], 2/3 gives H[31:16]. LHU zero-extends, LH sign-extends.
  - Word: H unchanged, data_offset ignored.
- When empty, cpu_out = 32'h0 regardless of data_type.
- empty = (count==0), full = (count==DEPTH); both are decoded from the count register.

## Timing
- Reset (asserted, asynchronous): wp=rp=0, count=0, empty=1, full=0, overflow=0, cpu_out=0. Storage contents are not reset.
- Reset asserted mid-operation clears all queued entries immediately. Deassertion is synchronous to clock by the system reset synchroniser.
- Push latency: word written on edge N appears on cpu_out after edge N if the FIFO was empty. count, empty and full update on the same edge.
- Pop: after the edge, cpu_out shows the next entry, or 0 if none remain.
- cpu_out, empty and full have no added registered latency beyond the storage, pointer and count registers. data_type and data_offset affect cpu_out combinationally in the same cycle.

## Configuration
- INPUT_FIFO_OVERFLOW_EN defined: overflow is a sticky register as described above, and clear_overflow is honoured.
- Not defined: overflow is tied to 0 and clear_overflow is ignored. Dropping on a full FIFO is unchanged. The port list is identical in both builds.

## Structure
- Package input_fifo_pkg holds the load-type localparams (LT_LB=3'b000, LT_LH=3'b001, LT_LBU=3'b100, LT_LHU=3'b101) and the shared extraction function prototype constants.
- Sub-module load_extract is purely combinational: inputs head word, data_type, data_offset, valid; output cpu_out. It is reused by future output/peek paths.
- Top level holds storage, pointers, count and the overflow flag.

## Test plan
- Reset, then idle: empty=1, full=0, count=0, cpu_out=0, overflow=0.
- Push 32'h8899_AABB, LB offset 0 → cpu_out=32'hFFFF_FFBB. LBU offset 3 → 32'h0000_0088. LH offset 2 → 32'hFFFF_8899. LHU offset 1 → 32'h0000_AABB.
- DEPTH=4: push 1,2,3,4 → full=1, count=4. Push 5 → dropped, overflow=1. Pop four times → LW values 1,2,3,4 in order, then empty=1, cpu_out=0.
- Full FIFO holding 1..4, write 5 with read on the same edge → count=4, overflow stays 0, subsequent pops give 2,3,4,5 (pointer wrap verified).
- Read while empty → count stays 0, no flag changes. clear_overflow while a drop occurs on the same edge → overflow=1. clear_overflow alone → 0.
- Assert reset_n low mid-stream with 3 entries held → count=0 and empty=1 immediately, without a clock edge. Build without INPUT_FIFO_OVERFLOW_EN → overflow always 0.
